// File: rtl/mem_wb_writeback_pkg.sv
// Shared writeback-source encoding and load funct3 codes for the RV32I pipeline.
package mem_wb_writeback_pkg;

   typedef enum logic [1:0] {
      WB_ALU  = 2'b00,
      WB_LOAD = 2'b01,
      WB_PC4  = 2'b10,
      WB_RSVD = 2'b11
   } wbsrc_t;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   function automatic logic is_half_load(input logic [2:0] funct3);
      return (funct3 == F3_LH) || (funct3 == F3_LHU);
   endfunction

endpackage

// File: rtl/mem_wb_writeback_load_formatter.sv
// Combinational load-data extraction and alignment check for LB/LH/LW/LBU/LHU.
module load_formatter
   import mem_wb_writeback_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] rdata,
   input  logic [1:0]      off,
   input  logic [2:0]      funct3,
   output logic [XLEN-1:0] data,
   output logic            mis
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = rdata[{off, 3'b000} +: 8];
      half_sel = rdata[{off[1], 4'b0000} +: 16];
      data     = '0;
      mis      = 1'b0;
      case (funct3)
         F3_LB:  data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
         F3_LBU: data = {{(XLEN-8){1'b0}}, byte_sel};
         F3_LH:  data = {{(XLEN-16){half_sel[15]}}, half_sel};
         F3_LHU: data = {{(XLEN-16){1'b0}}, half_sel};
         F3_LW: begin
            data = rdata;
            mis  = (off != 2'b00);
         end
         default: data = '0;
      endcase
      // Halfwords only need 2-byte alignment; the half select itself ignores off[0].
      if (is_half_load(funct3)) begin
         mis = off[0];
      end
   end

endmodule

// File: rtl/mem_wb_writeback.sv
// MEM/WB pipeline register with writeback select, misaligned-load flag and retire counter.
module mem_wb_writeback
   import mem_wb_writeback_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic             flush,
   input  logic             mem_valid,
   input  logic             mem_ruwr,
   input  logic [4:0]       mem_rd,
   input  logic [1:0]       mem_wbsrc,
   input  logic [2:0]       mem_funct3,
   input  logic [XLEN-1:0]  mem_alu_res,
   input  logic [XLEN-1:0]  mem_rdata,
   input  logic [XLEN-1:0]  mem_pc_inc,
   output logic             RUWr,
   output logic [4:0]       rd,
   output logic [XLEN-1:0]  RUDataWr,
   output logic             wb_valid,
   output logic             load_misalign,
   output logic [CNT_W-1:0] retired
);

   wbsrc_t          wbsrc;
   logic [XLEN-1:0] ld_data;
   logic [XLEN-1:0] sel;
   logic            ld_mis;
   logic            mis;
   logic            wr_en;

   assign wbsrc = wbsrc_t'(mem_wbsrc);

   load_formatter #(.XLEN(XLEN)) u_load_formatter (
      .rdata  (mem_rdata),
      .off    (mem_alu_res[1:0]),
      .funct3 (mem_funct3),
      .data   (ld_data),
      .mis    (ld_mis)
   );

   always_comb begin
      sel = '0;
      case (wbsrc)
         WB_ALU:  sel = mem_alu_res;
         WB_LOAD: sel = ld_data;
         WB_PC4:  sel = mem_pc_inc;
         default: sel = '0;
      endcase
   end

   assign mis   = mem_valid & (wbsrc == WB_LOAD) & ld_mis;
   assign wr_en = mem_valid & mem_ruwr & (mem_rd != 5'd0) & ~mis & (wbsrc != WB_RSVD);

   always_ff @(posedge clk) begin
      if (rst) begin
         RUWr          <= 1'b0;
         rd            <= 5'd0;
         RUDataWr      <= '0;
         wb_valid      <= 1'b0;
         load_misalign <= 1'b0;
         retired       <= '0;
      end else if (flush) begin
         // Bubble into WB; the retire count is not touched by a flush.
         RUWr          <= 1'b0;
         rd            <= 5'd0;
         RUDataWr      <= '0;
         wb_valid      <= 1'b0;
         load_misalign <= 1'b0;
      end else if (!stall) begin
         RUWr          <= wr_en;
         rd            <= mem_rd;
         RUDataWr      <= sel;
         wb_valid      <= mem_valid;
         load_misalign <= mis;
         retired       <= retired + {{(CNT_W-1){1'b0}}, mem_valid};
      end
   end

endmodule

// File: tb/tb_mem_wb_writeback.sv
// Self-checking bench: directed vector table, stall/flush/wrap sequences, randomized model check.
module tb_mem_wb_writeback;

   logic        clk = 1'b0;
   logic        rst, stall, flush, mem_valid, mem_ruwr;
   logic [4:0]  mem_rd;
   logic [1:0]  mem_wbsrc;
   logic [2:0]  mem_funct3;
   logic [31:0] mem_alu_res, mem_rdata, mem_pc_inc;

   logic        ruwr_o, wbv_o, mis_o;
   logic [4:0]  rd_o;
   logic [31:0] data_o, ret_o;
   logic        ruwr4_o, wbv4_o, mis4_o;
   logic [4:0]  rd4_o;
   logic [31:0] data4_o;
   logic [3:0]  ret4_o;

   int checks = 0;
   int errors = 0;

   // reference state
   logic        m_ruwr, m_valid, m_mis;
   logic [4:0]  m_rd;
   logic [31:0] m_data, m_ret;
   logic [3:0]  m_ret4;

   always #5 clk = ~clk;

   mem_wb_writeback #(.XLEN(32), .CNT_W(32)) dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .mem_valid(mem_valid), .mem_ruwr(mem_ruwr), .mem_rd(mem_rd),
      .mem_wbsrc(mem_wbsrc), .mem_funct3(mem_funct3), .mem_alu_res(mem_alu_res),
      .mem_rdata(mem_rdata), .mem_pc_inc(mem_pc_inc),
      .RUWr(ruwr_o), .rd(rd_o), .RUDataWr(data_o), .wb_valid(wbv_o),
      .load_misalign(mis_o), .retired(ret_o)
   );

   mem_wb_writeback #(.XLEN(32), .CNT_W(4)) dut4 (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .mem_valid(mem_valid), .mem_ruwr(mem_ruwr), .mem_rd(mem_rd),
      .mem_wbsrc(mem_wbsrc), .mem_funct3(mem_funct3), .mem_alu_res(mem_alu_res),
      .mem_rdata(mem_rdata), .mem_pc_inc(mem_pc_inc),
      .RUWr(ruwr4_o), .rd(rd4_o), .RUDataWr(data4_o), .wb_valid(wbv4_o),
      .load_misalign(mis4_o), .retired(ret4_o)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Load result computed from the architectural rules with plain arithmetic.
   task automatic ref_load(input logic [2:0] f3, input int off, input logic [31:0] w,
                           output logic [31:0] d, output logic bad);
      int unsigned b, h;
      b = (w >> (8 * off)) & 32'hFF;
      h = (w >> (16 * (off / 2))) & 32'hFFFF;
      bad = 1'b0;
      d = 32'h0;
      if (f3 == 3'd0) d = (b >= 128) ? b + 32'hFFFFFF00 : b;
      else if (f3 == 3'd4) d = b;
      else if (f3 == 3'd1 || f3 == 3'd5) begin
         d = (f3 == 3'd1 && h >= 32768) ? h + 32'hFFFF0000 : h;
         bad = (off % 2) == 1;
      end else if (f3 == 3'd2) begin
         d = w;
         bad = off != 0;
      end
   endtask

   task automatic model_clock();
      logic [31:0] ld, sel;
      logic bad;
      if (rst) begin
         m_ruwr = 0; m_rd = 0; m_data = 0; m_valid = 0; m_mis = 0; m_ret = 0; m_ret4 = 0;
      end else if (flush) begin
         m_ruwr = 0; m_rd = 0; m_data = 0; m_valid = 0; m_mis = 0;
      end else if (!stall) begin
         ref_load(mem_funct3, int'(mem_alu_res % 4), mem_rdata, ld, bad);
         bad = bad && mem_valid && mem_wbsrc == 2'd1;
         if (mem_wbsrc == 2'd0) sel = mem_alu_res;
         else if (mem_wbsrc == 2'd1) sel = ld;
         else if (mem_wbsrc == 2'd2) sel = mem_pc_inc;
         else sel = 0;
         m_ruwr  = mem_valid && mem_ruwr && mem_rd != 0 && !bad && mem_wbsrc != 2'd3;
         m_rd    = mem_rd;
         m_data  = sel;
         m_valid = mem_valid;
         m_mis   = bad;
         if (mem_valid) begin
            m_ret  = m_ret + 1;
            m_ret4 = m_ret4 + 1;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_clock();
      #1;
   endtask

   task automatic check_model(input string tag);
      chk({tag, ".RUWr"}, {31'd0, ruwr_o}, {31'd0, m_ruwr});
      chk({tag, ".rd"}, {27'd0, rd_o}, {27'd0, m_rd});
      if (!m_mis) chk({tag, ".RUDataWr"}, data_o, m_data);
      chk({tag, ".wb_valid"}, {31'd0, wbv_o}, {31'd0, m_valid});
      chk({tag, ".load_misalign"}, {31'd0, mis_o}, {31'd0, m_mis});
      chk({tag, ".retired"}, ret_o, m_ret);
      chk({tag, ".retired4"}, {28'd0, ret4_o}, {28'd0, m_ret4});
   endtask

   task automatic drive(input logic v, input logic w, input logic [4:0] r, input logic [1:0] s,
                        input logic [2:0] f, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] p);
      mem_valid = v; mem_ruwr = w; mem_rd = r; mem_wbsrc = s;
      mem_funct3 = f; mem_alu_res = a; mem_rdata = d; mem_pc_inc = p;
   endtask

   task automatic drive_random();
      drive(1'b1, 1'($urandom), 5'($urandom), 2'($urandom), 3'($urandom),
            $urandom, $urandom, $urandom);
   endtask

   typedef struct {
      string       name;
      logic [2:0]  f3;
      logic [1:0]  src;
      logic [4:0]  rd;
      logic [31:0] alu, rdata, pc;
      logic        e_ruwr;
      logic [31:0] e_data;
      logic        e_mis;
   } vec_t;

   vec_t vecs[8];

   initial begin
      logic [31:0] hold_data, hold_ret;
      logic [4:0]  hold_rd;
      logic        hold_ruwr;

      vecs[0] = '{"lb",    3'd0, 2'd1, 5'd5, 32'h1003, 32'h80FF1234, 32'h0,   1'b1, 32'hFFFFFF80, 1'b0};
      vecs[1] = '{"lbu",   3'd4, 2'd1, 5'd5, 32'h1003, 32'h80FF1234, 32'h0,   1'b1, 32'h00000080, 1'b0};
      vecs[2] = '{"lh2",   3'd1, 2'd1, 5'd6, 32'h1002, 32'h80010000, 32'h0,   1'b1, 32'hFFFF8001, 1'b0};
      vecs[3] = '{"lh1",   3'd1, 2'd1, 5'd6, 32'h1001, 32'h80010000, 32'h0,   1'b0, 32'h0,        1'b1};
      vecs[4] = '{"rd0",   3'd0, 2'd0, 5'd0, 32'h1234, 32'h0,        32'h0,   1'b0, 32'h00001234, 1'b0};
      vecs[5] = '{"pc4",   3'd0, 2'd2, 5'd1, 32'h0,    32'h0,        32'h104, 1'b1, 32'h00000104, 1'b0};
      vecs[6] = '{"rsvd",  3'd0, 2'd3, 5'd7, 32'h55,   32'h0,        32'h200, 1'b0, 32'h0,        1'b0};
      vecs[7] = '{"lw",    3'd2, 2'd1, 5'd9, 32'h2000, 32'hDEADBEEF, 32'h0,   1'b1, 32'hDEADBEEF, 1'b0};

      // reset with busy inputs
      stall = 0; flush = 0; rst = 1;
      drive(1'b1, 1'b1, 5'd3, 2'd0, 3'd0, 32'hCAFE, 32'h1, 32'h2);
      tick(); tick();
      chk("reset.RUWr", {31'd0, ruwr_o}, 32'd0);
      chk("reset.rd", {27'd0, rd_o}, 32'd0);
      chk("reset.RUDataWr", data_o, 32'd0);
      chk("reset.wb_valid", {31'd0, wbv_o}, 32'd0);
      chk("reset.load_misalign", {31'd0, mis_o}, 32'd0);
      chk("reset.retired", ret_o, 32'd0);
      rst = 0;

      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 1'b1, vecs[i].rd, vecs[i].src, vecs[i].f3, vecs[i].alu, vecs[i].rdata, vecs[i].pc);
         tick();
         chk({vecs[i].name, ".RUWr"}, {31'd0, ruwr_o}, {31'd0, vecs[i].e_ruwr});
         chk({vecs[i].name, ".rd"}, {27'd0, rd_o}, {27'd0, vecs[i].rd});
         if (!vecs[i].e_mis) chk({vecs[i].name, ".RUDataWr"}, data_o, vecs[i].e_data);
         chk({vecs[i].name, ".load_misalign"}, {31'd0, mis_o}, {31'd0, vecs[i].e_mis});
         chk({vecs[i].name, ".retired"}, ret_o, 32'(i + 1));
         check_model(vecs[i].name);
      end

      // stall for 3 cycles with changing inputs
      drive(1'b1, 1'b1, 5'd12, 2'd0, 3'd0, 32'hA5A5_0001, 32'h0, 32'h0);
      tick();
      hold_ruwr = ruwr_o; hold_rd = rd_o; hold_data = data_o; hold_ret = ret_o;
      chk("pre_stall.RUDataWr", data_o, 32'hA5A50001);
      stall = 1;
      for (int i = 0; i < 3; i++) begin
         drive_random();
         tick();
         chk("stall.RUWr", {31'd0, ruwr_o}, {31'd0, hold_ruwr});
         chk("stall.rd", {27'd0, rd_o}, {27'd0, hold_rd});
         chk("stall.RUDataWr", data_o, hold_data);
         chk("stall.retired", ret_o, hold_ret);
      end
      flush = 1;
      drive_random();
      tick();
      chk("flush_stall.RUWr", {31'd0, ruwr_o}, 32'd0);
      chk("flush_stall.wb_valid", {31'd0, wbv_o}, 32'd0);
      chk("flush_stall.retired", ret_o, hold_ret);
      check_model("flush_stall");
      stall = 0; flush = 0;

      // retire-counter wrap on the 4-bit instance
      rst = 1; tick(); rst = 0;
      for (int i = 0; i < 16; i++) begin
         drive_random();
         tick();
      end
      chk("wrap.retired4", {28'd0, ret4_o}, 32'd0);
      chk("wrap.retired", ret_o, 32'd16);
      for (int i = 0; i < 5; i++) begin
         drive_random();
         mem_valid = 0;
         tick();
      end
      chk("novalid.retired4", {28'd0, ret4_o}, 32'd0);
      chk("novalid.retired", ret_o, 32'd16);
      chk("novalid.wb_valid", {31'd0, wbv_o}, 32'd0);
      chk("novalid.RUWr", {31'd0, ruwr_o}, 32'd0);

      // randomized traffic against the reference model
      for (int i = 0; i < 400; i++) begin
         drive_random();
         mem_valid = ($urandom_range(0, 3) != 0);
         rst   = ($urandom_range(0, 39) == 0);
         flush = ($urandom_range(0, 9) == 0);
         stall = ($urandom_range(0, 7) == 0);
         tick();
         check_model("rand");
      end
      rst = 0; flush = 0; stall = 0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
